// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment display blocks: hex glyph table,
// blank pattern, slot-state encoding and a constant clog2 helper.
package seg_disp_pkg;

  // All segments off (active-low cathodes, dp included).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyphs for 0..F with the dp bit (bit 7) held off.
  localparam logic [7:0] HEX_SEG [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Phase of the current digit slot.
  typedef enum logic [1:0] {
    SLOT_DEAD,
    SLOT_ON,
    SLOT_OFF
  } slot_state_e;

  // Ceiling log2, usable in parameter and port-width expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
// Shared by every display block that drives a seven-segment digit.
module seg_hex_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, HEX_SEG[nibble][6:0]};

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Scans NUM_DIGITS digits, one slot per digit; each slot is a blank dead time,
// a PWM lit window of min(brightness, SLOT_TICKS-DEAD_TICKS) ticks, then off.
// New digit values are staged by load and swapped in only at frame boundaries.
// Optional: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits as
// values are latched into the active set.
module seven_seg_scan_ctrl
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 25000,
  parameter int SLOT_TICKS = 16,
  parameter int DEAD_TICKS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       data_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         dig_en,
  input  logic                          load,
  input  logic [clog2(SLOT_TICKS)-1:0]  brightness,
  output logic [7:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_start,
  output logic                          load_pending
);

  localparam int PRE_W  = clog2(CLK_DIV);
  localparam int SLOT_W = clog2(SLOT_TICKS);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam int ON_MAX = SLOT_TICKS - DEAD_TICKS;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_TICKS);
  localparam logic [SLOT_W-1:0] ON_LIMIT  = SLOT_W'(ON_MAX);

  // Timebase
  logic [PRE_W-1:0]  presc;
  logic              tick;
  logic              slot_wrap;
  logic              frame_tick;

  // Slot sequencing
  logic [SLOT_W-1:0] slot_cnt, slot_d;
  logic [SLOT_W-1:0] on_t_q, on_t_d;
  logic [SLOT_W:0]   on_end;
  logic [IDX_W-1:0]  idx;
  slot_state_e       state_q, state_d;

  // Staging and active digit sets
  logic [4*NUM_DIGITS-1:0] stg_data, act_data, lat_data;
  logic [NUM_DIGITS-1:0]   stg_dp,   act_dp,   lat_dp;
  logic [NUM_DIGITS-1:0]   stg_en,   act_en,   lat_en, lat_en_f;

  // Output path
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [7:0]            dec_seg;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  assign tick       = (presc == PRE_LAST);
  assign slot_wrap  = tick && (slot_cnt == SLOT_LAST);
  assign frame_tick = slot_wrap && (idx == IDX_LAST);

  // Prescaler: free-running 0..CLK_DIV-1, tick on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Digit index advances each time the slot counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (slot_wrap) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Slot FSM state register: slot counter, held lit width and phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      on_t_q   <= '0;
      state_q  <= SLOT_DEAD;
    end else begin
      slot_cnt <= slot_d;
      on_t_q   <= on_t_d;
      state_q  <= state_d;
    end
  end

  assign on_end = (SLOT_W + 1)'(DEAD_TICKS) + {1'b0, on_t_q};

  // Slot FSM next state: phase tracks the counter value the next edge loads.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    slot_d  = slot_cnt;
    on_t_d  = on_t_q;
    state_d = state_q;
    if (slot_wrap) begin
      slot_d  = '0;
      on_t_d  = (brightness > ON_LIMIT) ? ON_LIMIT : brightness;
      state_d = SLOT_DEAD;
    end else if (tick) begin
      slot_d = slot_cnt + 1'b1;
      if (slot_d < DEAD_END) begin
        state_d = SLOT_DEAD;
      end else if ({1'b0, slot_d} < on_end) begin
        state_d = SLOT_ON;
      end else begin
        state_d = SLOT_OFF;
      end
    end
  end

  // Source of a latch into the active set: a coincident load bypasses staging.
  always_comb begin
    lat_data = stg_data;
    lat_dp   = stg_dp;
    lat_en   = stg_en;
    if (load) begin
      lat_data = data_in;
      lat_dp   = dp_in;
      lat_en   = dig_en;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic seen_nz;

  // Clear enables of zero, dp-less digits above the top nonzero nibble.
  always_comb begin
    lat_en_f = lat_en;
    seen_nz  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lat_data[i*4 +: 4] != 4'h0) begin
        seen_nz = 1'b1;
      end else if (!seen_nz && !lat_dp[i]) begin
        lat_en_f[i] = 1'b0;
      end
    end
  end
`else
  assign lat_en_f = lat_en;
`endif

  // Load handshake: stage on load, promote to active at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are plain registers, not a RAM, so they are reset; that is
    // what guarantees a dark display (all enables 0) straight out of reset.
    if (rst) begin
      stg_data     <= '0;
      stg_dp       <= '0;
      stg_en       <= '0;
      act_data     <= '0;
      act_dp       <= '0;
      act_en       <= '0;
      load_pending <= 1'b0;
    end else if (frame_tick && (load || load_pending)) begin
      act_data     <= lat_data;
      act_dp       <= lat_dp;
      act_en       <= lat_en_f;
      load_pending <= 1'b0;
    end else if (load) begin
      stg_data     <= data_in;
      stg_dp       <= dp_in;
      stg_en       <= dig_en;
      load_pending <= 1'b1;
    end
  end

  // Select the nibble and dp of the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = act_data[i*4 +: 4];
        cur_dp  = act_dp[i];
      end
    end
  end

  seg_hex_decode u_hex_decode (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  // Pin values for the current phase; only the ON phase drives anything.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (state_q == SLOT_ON) begin
      seg_d = dec_seg;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((idx == IDX_W'(i)) && act_en[i]) begin
          an_d[i] = 1'b0;
        end
      end
    end
  end

  // Output registers: seg and an update on the same edge, frame_start pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg         <= SEG_BLANK;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_d;
      an          <= an_d;
      frame_start <= frame_tick;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, CLK_DIV=4,
// SLOT_TICKS=8, DEAD_TICKS=1: slot = 32 clk, frame = 128 clk).
// The stimulus side predicts each frame's displayed contents and queues them;
// a monitor pops one record per frame_start and checks every pin cycle.
module tb_seven_seg_scan_ctrl;

  localparam int N_FRAMES = 15;
  localparam int N_EDGES  = 128 * N_FRAMES;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [2:0]  bright;
    logic        pend_before;
  } frame_t;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en;
  logic        load;
  logic [2:0]  brightness;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
  logic        load_pending;

  int     n_cmp = 0;
  int     n_bad = 0;
  frame_t exp_q[$];
  logic   mon_done = 1'b0;

  // Reference state of the load handshake.
  logic [15:0] m_stg_data, m_act_data;
  logic [3:0]  m_stg_dp, m_act_dp, m_stg_en, m_act_en;
  logic        m_pend;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .CLK_DIV    (4),
    .SLOT_TICKS (8),
    .DEAD_TICKS (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .dp_in        (dp_in),
    .dig_en       (dig_en),
    .load         (load),
    .brightness   (brightness),
    .seg          (seg),
    .an           (an),
    .frame_start  (frame_start),
    .load_pending (load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Enables as they land in the active set (leading-zero rule when built in).
  function automatic logic [3:0] lat_enables(input logic [15:0] d,
                                             input logic [3:0] dp,
                                             input logic [3:0] en);
    logic [3:0] r;
    int ms;
    r  = en;
    ms = -1;
    for (int i = 0; i < 4; i++)
      if (((d >> (4 * i)) & 16'hF) != 16'h0) ms = i;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < 4; i++)
      if (i > ms && !dp[i]) r[i] = 1'b0;
`endif
    return r;
  endfunction

  // Expected {an, seg} for cycle c (0..127) of a frame.
  function automatic logic [11:0] exp_pins(input frame_t r, input int c);
    int d, s, on_t;
    logic [3:0] nib, a;
    logic [7:0] g;
    d    = c / 32;
    s    = (c % 32) / 4;
    on_t = (int'(r.bright) > 7) ? 7 : int'(r.bright);
    nib  = 4'((r.data >> (4 * d)) & 16'hF);
    a    = 4'hF;
    g    = 8'hFF;
    if (s >= 1 && s < 1 + on_t) begin
      if (r.en[d]) a[d] = 1'b0;
      g = {~r.dp[d], HEX[nib][6:0]};
    end
    return {a, g};
  endfunction

  // Drive inputs for upcoming posedge number n and advance the reference.
  task automatic drive_edge(input int n);
    logic do_ld;
    logic is_frame;
    frame_t r;
    do_ld    = 1'b0;
    is_frame = (n % 128 == 0);
    data_in  = 16'($urandom);
    dp_in    = 4'($urandom);
    dig_en   = 4'($urandom);
    case (n)
      40:  begin do_ld = 1'b1; data_in = 16'h1234; dp_in = 4'h0; dig_en = 4'hF; end
      300: begin do_ld = 1'b1; data_in = 16'hABCD; dp_in = 4'h0; dig_en = 4'hF; end
      340: begin do_ld = 1'b1; data_in = 16'h5678; dp_in = 4'h0; dig_en = 4'hF; end
      512: begin do_ld = 1'b1; data_in = 16'h9E0F; dp_in = 4'b0100; dig_en = 4'hF; end
      600: begin do_ld = 1'b1; dp_in = 4'b0010; dig_en = 4'b1011; end
      default: begin
        if (n > 640)
          do_ld = is_frame ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      end
    endcase
    if (is_frame) begin
      case (n / 128)
        1:       brightness = 3'd7;
        2:       brightness = 3'd0;
        3:       brightness = 3'd7;
        4:       brightness = 3'd6;
        5:       brightness = 3'd5;
        default: brightness = 3'($urandom_range(0, 7));
      endcase
    end
    load = do_ld;

    if (is_frame) begin
      r.pend_before = m_pend;
      if (do_ld) begin
        m_act_data = data_in;
        m_act_dp   = dp_in;
        m_act_en   = lat_enables(data_in, dp_in, dig_en);
      end else if (m_pend) begin
        m_act_data = m_stg_data;
        m_act_dp   = m_stg_dp;
        m_act_en   = lat_enables(m_stg_data, m_stg_dp, m_stg_en);
      end
      m_pend   = 1'b0;
      r.data   = m_act_data;
      r.dp     = m_act_dp;
      r.en     = m_act_en;
      r.bright = brightness;
      exp_q.push_back(r);
    end else if (do_ld) begin
      m_stg_data = data_in;
      m_stg_dp   = dp_in;
      m_stg_en   = dig_en;
      m_pend     = 1'b1;
    end
  endtask

  // Monitor: each frame_start opens a 128-cycle window checked against a record.
  initial begin : monitor
    frame_t r;
    logic   prev_pend, cur_pend;
    int     w;
    prev_pend = 1'b0;
    cur_pend  = 1'b0;
    w = 0;
    while (w < 400 && frame_start !== 1'b1) begin
      @(negedge clk);
      prev_pend = cur_pend;
      cur_pend  = load_pending;
      w++;
    end
    check("first_frame_start_seen", {31'd0, frame_start}, 32'd1);
    if (frame_start === 1'b1) begin
      for (int f = 0; f < N_FRAMES; f++) begin
        if (exp_q.size() == 0) begin
          check($sformatf("f%0d_record_available", f), 32'd0, 32'd1);
          break;
        end
        r = exp_q.pop_front();
        check($sformatf("f%0d_pending_before_boundary", f), {31'd0, prev_pend},
              {31'd0, r.pend_before});
        check($sformatf("f%0d_pending_after_boundary", f), {31'd0, cur_pend}, 32'd0);
        for (int j = 1; j <= 128; j++) begin
          @(negedge clk);
          prev_pend = cur_pend;
          cur_pend  = load_pending;
          check($sformatf("f%0d_c%0d_an_seg", f, j - 1), {20'd0, an, seg},
                {20'd0, exp_pins(r, j - 1)});
          check($sformatf("f%0d_c%0d_frame_start", f, j - 1), {31'd0, frame_start},
                (j == 128) ? 32'd1 : 32'd0);
        end
      end
    end
    mon_done = 1'b1;
  end

  initial begin : stimulus
    int w;
    m_stg_data = '0; m_stg_dp = '0; m_stg_en = '0;
    m_act_data = '0; m_act_dp = '0; m_act_en = '0;
    m_pend     = 1'b0;
    rst = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; dig_en = '0; brightness = '0;

    // Reset applied before any clock edge must still clear the outputs.
    #1 rst = 1'b1;
    #1;
    check("reset_seg", {24'd0, seg}, 32'hFF);
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_frame_start", {31'd0, frame_start}, 32'd0);
    check("reset_load_pending", {31'd0, load_pending}, 32'd0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= N_EDGES; n++) begin
      drive_edge(n);
      @(negedge clk);
    end
    load = 1'b0;

    w = 0;
    while (w < 400 && !mon_done) begin
      @(negedge clk);
      w++;
    end
    check("monitor_finished", {31'd0, mon_done}, 32'd1);

    // Asynchronous reset in the middle of a lit window.
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    data_in    = 16'h1234;
    dp_in      = 4'h0;
    dig_en     = 4'hF;
    brightness = 3'd7;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
    w = 0;
    while (w < 300 && frame_start !== 1'b1) begin
      @(negedge clk);
      w++;
    end
    check("rst_phase_frame_start_seen", {31'd0, frame_start}, 32'd1);
    w = 0;
    while (w < 64 && an === 4'hF) begin
      @(negedge clk);
      w++;
    end
    check("rst_phase_digit0_lit", {28'd0, an}, 32'hE);
    #2 rst = 1'b1;
    #1;
    check("midon_reset_seg", {24'd0, seg}, 32'hFF);
    check("midon_reset_an", {28'd0, an}, 32'hF);
    check("midon_reset_load_pending", {31'd0, load_pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
